// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types used by the blocks that sit on the
// display timing, including the vblank-gated RAM write arbiter.
package vga_pkg;

    localparam int V_BLANK_START = 768;
    localparam int V_TOTAL_TIME  = 806;

    // Last line (exclusive) on which board/text RAM writes may land, with the
    // default two guard lines kept clear before the next frame starts.
    localparam int WRITE_WIN_END = V_TOTAL_TIME - 2;

    typedef enum logic [1:0] {
        DISPLAY,
        ARB,
        BURST
    } vbw_state_t;

endpackage

// File: rtl/vblank_write_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// when searching upward from ptr+1 (wrapping), so the pointer holder goes last.
module rr_picker #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan farthest-to-nearest so the candidate closest after ptr wins.
    always_comb begin
        int             w_j;
        logic [IDX_W-1:0] w_jj;
        found = 1'b0;
        idx   = '0;
        w_j   = 0;
        w_jj  = '0;
        for (int k = N; k >= 1; k--) begin
            w_j  = (int'(ptr) + k) % N;
            w_jj = IDX_W'(w_j);
            if (req[w_jj]) begin
                found = 1'b1;
                idx   = w_jj;
            end
        end
    end

endmodule

// File: rtl/vblank_write_arbiter.sv
// Shares the single write port of the board/text RAM among several game-logic
// requesters. Writes only land during vertical blanking (minus guard lines) so
// the draw pipeline never sees a half-updated frame. Round-robin grants with
// bursts capped at MAX_BURST words and a one-cycle bubble per grant change.
module vblank_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int MAX_BURST   = 8,
    parameter int GUARD_LINES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [10:0]               vcount,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data,
    output logic                      busy
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int WIN_END = V_TOTAL_TIME - GUARD_LINES;

    vbw_state_t         r_state;
    vbw_state_t         w_state_next;
    logic [IDX_W-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [7:0]         r_burst_cnt;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_data;
    logic               r_busy;

    logic               w_win;
    logic               w_pick_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_gnt_req;
    logic [NUM_REQ-1:0] w_ack;
    logic               w_ack_any;
    logic               w_burst_last;
    logic               w_leave;
    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

    // Unpack the flat request buses into per-requester slices.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_win = (vcount >= 11'(V_BLANK_START)) && (vcount < 11'(WIN_END));

    assign w_gnt_req    = req[r_gnt];
    assign w_ack_any    = |w_ack;
    assign w_burst_last = w_ack_any && (r_burst_cnt == 8'(MAX_BURST - 1));

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (req),
        .ptr   (r_rr_ptr),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    // Ack the granted requester only while it still requests and the window is open.
    always_comb begin
        w_ack = '0;
        if ((r_state == BURST) && w_gnt_req && w_win) begin
            w_ack[r_gnt] = 1'b1;
        end
    end

    // Next-state decision; w_leave marks the cycle a grant is released.
    always_comb begin
        w_state_next = r_state;
        w_leave      = 1'b0;
        case (r_state)
            DISPLAY: begin
                if (w_win) w_state_next = ARB;
            end
            ARB: begin
                if (!w_win)            w_state_next = DISPLAY;
                else if (w_pick_found) w_state_next = BURST;
            end
            BURST: begin
                if (!w_win || !w_gnt_req || w_burst_last) begin
                    w_leave      = 1'b1;
                    w_state_next = w_win ? ARB : DISPLAY;
                end
            end
            default: w_state_next = DISPLAY;
        endcase
    end

    // All arbiter state plus the registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DISPLAY;
            r_gnt       <= '0;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next == BURST);
            r_mem_we <= w_ack_any;
            if (w_ack_any) begin
                r_mem_addr  <= w_addr_arr[r_gnt];
                r_mem_data  <= w_data_arr[r_gnt];
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
            if ((r_state == ARB) && w_win && w_pick_found) begin
                r_gnt       <= w_pick_idx;
                r_burst_cnt <= '0;
            end
            if (w_leave) begin
                r_rr_ptr <= r_gnt;
            end
        end
    end

    assign ack      = w_ack;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Directed bench for vblank_write_arbiter: reset/idle, single burst,
// round-robin contention, window close mid-burst, async reset mid-burst and a
// short random-traffic phase with protocol assertions running throughout.
module tb_vblank_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [10:0]               vcount;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic                      busy;

    vblank_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BURST(MAX_BURST), .GUARD_LINES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vcount(vcount), .req(req),
        .req_addr(req_addr), .req_data(req_data), .ack(ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int words_left [NUM_REQ];
    int word_idx   [NUM_REQ];

    logic [NUM_REQ-1:0] obs_ack;
    logic               obs_we;
    logic               obs_busy;
    logic [ADDR_W-1:0]  obs_addr, exp_addr;
    logic [DATA_W-1:0]  obs_data, exp_data;

    logic tb_win;
    assign tb_win = (vcount >= 11'd768) && (vcount < 11'd804);

    // Protocol assertions, active whenever reset is released.
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack))
        else begin n_fail++; $display("FAIL assert_onehot ack=%b", ack); end
    a_no_req: assert property (@(posedge clk) disable iff (!rst_n) (ack & ~req) == '0)
        else begin n_fail++; $display("FAIL assert_ack_without_req ack=%b req=%b", ack, req); end
    a_win: assert property (@(posedge clk) disable iff (!rst_n) !tb_win |-> ack == '0)
        else begin n_fail++; $display("FAIL assert_ack_outside_window ack=%b vcount=%0d", ack, vcount); end
    a_we: assert property (@(posedge clk) disable iff (!rst_n) mem_we == $past(|ack))
        else begin n_fail++; $display("FAIL assert_we_latency mem_we=%b", mem_we); end

    function automatic logic [ADDR_W-1:0] word_addr(int i, int k);
        return ADDR_W'(i * 256 + k);
    endfunction

    function automatic logic [DATA_W-1:0] word_data(int i, int k);
        return DATA_W'(48 + i * 16 + k * 3);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (words_left[i] > 0);
            req_addr[i*ADDR_W +: ADDR_W] = word_addr(i, word_idx[i]);
            req_data[i*DATA_W +: DATA_W] = word_data(i, word_idx[i]);
        end
    endtask

    // One clock of traffic: called at posedge+1, samples ack mid-cycle and the
    // registered outputs just after the next edge; requesters advance on ack.
    task automatic tick();
        drive_inputs();
        #1;
        obs_ack  = ack;
        exp_addr = '0;
        exp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (obs_ack[i]) begin
                exp_addr = word_addr(i, word_idx[i]);
                exp_data = word_data(i, word_idx[i]);
            end
        end
        @(posedge clk);
        #1;
        obs_we   = mem_we;
        obs_addr = mem_addr;
        obs_data = mem_data;
        obs_busy = busy;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (obs_ack[i]) begin
                words_left[i]--;
                word_idx[i]++;
            end
        end
    endtask

    task automatic clear_words();
        for (int i = 0; i < NUM_REQ; i++) begin
            words_left[i] = 0;
            word_idx[i]   = 0;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int seen;
        rst_n  = 1'b0;
        vcount = 11'd100;
        for (int i = 0; i < NUM_REQ; i++) begin
            words_left[i] = 50;
            word_idx[i]   = 0;
        end
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (mem_addr !== '0 || mem_data !== '0) begin
            n_fail++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_data);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int v = 100; v <= 767; v++) begin
            vcount = 11'(v);
            tick();
            if (obs_ack != 0 || obs_we || obs_busy) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL idle_display_lines got=%0d active cycles exp=0", seen); end
        $display("[TB] reset/idle: %0d active cycles on lines 100..767", seen);
        clear_words();
    endtask

    task automatic test_single_burst();
        logic [3:0] e_ack  [6];
        logic       e_we   [6];
        logic       e_busy [6];
        e_ack  = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
        e_we   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        words_left[1] = 3;
        vcount = 11'd770;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_tests++;
            if (obs_ack !== e_ack[t] || obs_we !== e_we[t] || obs_busy !== e_busy[t]) begin
                n_fail++;
                $display("FAIL single_burst_cycle%0d got ack=%b we=%b busy=%b exp ack=%b we=%b busy=%b",
                         t, obs_ack, obs_we, obs_busy, e_ack[t], e_we[t], e_busy[t]);
            end
            if (e_we[t]) begin
                n_tests++;
                if (obs_addr !== word_addr(1, t - 2) || obs_data !== word_data(1, t - 2)) begin
                    n_fail++;
                    $display("FAIL single_burst_word%0d got=%h/%h exp=%h/%h", t - 2,
                             obs_addr, obs_data, word_addr(1, t - 2), word_data(1, t - 2));
                end
            end
            $display("[TB] single t=%0d ack=%b we=%b addr=%h data=%h busy=%b", t, obs_ack, obs_we, obs_addr, obs_data, obs_busy);
        end
    endtask

    task automatic test_contention();
        int run_id[$];
        int run_len[$];
        int gap[$];
        int e_id[6];
        int e_len[6];
        int e_gap[6];
        int cur, idle, id, cyc;
        e_id  = '{0, 2, 0, 2, 0, 2};
        e_len = '{8, 8, 8, 8, 4, 4};
        e_gap = '{2, 1, 1, 1, 1, 2};
        pulse_reset();
        clear_words();
        words_left[0] = 20;
        words_left[2] = 20;
        vcount = 11'd770;
        cur = -1; idle = 0; cyc = 0;
        while ((words_left[0] > 0 || words_left[2] > 0) && cyc < 200) begin
            tick();
            cyc++;
            if (obs_ack != 0) begin
                id = -1;
                for (int i = 0; i < NUM_REQ; i++) if (obs_ack[i]) id = i;
                n_tests++;
                if (obs_we !== 1'b1 || obs_addr !== exp_addr || obs_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL contention_write got we=%b %h/%h exp=1 %h/%h", obs_we, obs_addr, obs_data, exp_addr, exp_data);
                end
                if (id == cur && idle == 0) begin
                    run_len[run_len.size() - 1]++;
                end else begin
                    run_id.push_back(id);
                    run_len.push_back(1);
                    gap.push_back(idle);
                end
                cur = id;
                idle = 0;
            end else begin
                idle++;
            end
        end
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL contention_timeout got=%0d cycles exp<200", cyc); end
        n_tests++;
        if (run_id.size() != 6) begin
            n_fail++; $display("FAIL contention_grant_count got=%0d exp=6", run_id.size());
        end else begin
            for (int r = 0; r < 6; r++) begin
                $display("[TB] contention grant %0d: req%0d x%0d after %0d bubble(s)", r, run_id[r], run_len[r], gap[r]);
                n_tests++;
                if (run_id[r] != e_id[r] || run_len[r] != e_len[r] || gap[r] != e_gap[r]) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d got=%0d:%0d gap%0d exp=%0d:%0d gap%0d",
                             r, run_id[r], run_len[r], gap[r], e_id[r], e_len[r], e_gap[r]);
                end
            end
        end
        tick();
        n_tests++; if (obs_ack !== 4'h0 || obs_busy !== 1'b0) begin
            n_fail++; $display("FAIL contention_release got ack=%b busy=%b exp ack=0000 busy=0", obs_ack, obs_busy);
        end
    endtask

    task automatic test_window_close();
        logic [3:0] e_ack [5];
        int late;
        e_ack = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8};
        words_left[3] = 1000;
        word_idx[3]   = 0;
        vcount = 11'd803;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_tests++;
            if (obs_ack !== e_ack[t]) begin
                n_fail++; $display("FAIL winclose_803_cycle%0d got=%b exp=%b", t, obs_ack, e_ack[t]);
            end
            $display("[TB] winclose v=803 t=%0d ack=%b we=%b", t, obs_ack, obs_we);
        end
        n_tests++; if (obs_we !== 1'b1 || obs_addr !== word_addr(3, 3)) begin
            n_fail++; $display("FAIL winclose_last_write got we=%b addr=%h exp we=1 addr=%h", obs_we, obs_addr, word_addr(3, 3));
        end
        late = 0;
        for (int t = 0; t < 4; t++) begin
            vcount = (t < 2) ? 11'd804 : 11'd805;
            tick();
            if (obs_ack != 0 || obs_we) late++;
        end
        vcount = 11'd0;   tick(); if (obs_ack != 0) late++;
        vcount = 11'd500; tick(); if (obs_ack != 0) late++;
        n_tests++; if (late !== 0) begin n_fail++; $display("FAIL winclose_guard got=%0d writes exp=0", late); end
        n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL winclose_busy got=%b exp=0", obs_busy); end
        vcount = 11'd768;
        tick();
        n_tests++; if (obs_ack !== 4'h0) begin n_fail++; $display("FAIL winclose_resume_arb got=%b exp=0000", obs_ack); end
        tick();
        n_tests++; if (obs_ack !== 4'h0) begin n_fail++; $display("FAIL winclose_resume_bubble got=%b exp=0000", obs_ack); end
        tick();
        n_tests++; if (obs_ack !== 4'h8 || obs_addr !== word_addr(3, 4)) begin
            n_fail++; $display("FAIL winclose_resume got ack=%b addr=%h exp ack=1000 addr=%h", obs_ack, obs_addr, word_addr(3, 4));
        end
        $display("[TB] winclose resume v=768 ack=%b addr=%h", obs_ack, obs_addr);
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] e1 [4];
        logic [3:0] e2 [3];
        logic [3:0] e3 [3];
        e1 = '{4'h0, 4'h2, 4'h2, 4'h0};
        e2 = '{4'h0, 4'h4, 4'h4};
        e3 = '{4'h0, 4'h0, 4'h2};
        words_left[3] = 0;
        tick();
        n_tests++; if (obs_ack !== 4'h0 || obs_busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_req_release got ack=%b busy=%b exp 0000/0", obs_ack, obs_busy);
        end
        words_left[1] = 2;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_tests++; if (obs_ack !== e1[t]) begin n_fail++; $display("FAIL rst_setup1_cycle%0d got=%b exp=%b", t, obs_ack, e1[t]); end
        end
        words_left[2] = 5;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++; if (obs_ack !== e2[t]) begin n_fail++; $display("FAIL rst_setup2_cycle%0d got=%b exp=%b", t, obs_ack, e2[t]); end
        end
        drive_inputs();
        #1;
        n_tests++; if (ack !== 4'h4 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rst_third_word_pre got ack=%b we=%b exp 0100/1", ack, mem_we);
        end
        rst_n = 1'b0;
        #1;
        n_tests++; if (mem_we !== 1'b0 || ack !== 4'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got we=%b ack=%b busy=%b exp 0/0000/0", mem_we, ack, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (mem_we !== 1'b0 || ack !== 4'h0) begin
            n_fail++; $display("FAIL rst_hold got we=%b ack=%b exp 0/0000", mem_we, ack);
        end
        rst_n = 1'b1;
        words_left[1] = 3;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++; if (obs_ack !== e3[t]) begin n_fail++; $display("FAIL rst_after_cycle%0d got=%b exp=%b", t, obs_ack, e3[t]); end
            $display("[TB] after reset t=%0d ack=%b we=%b", t, obs_ack, obs_we);
        end
        n_tests++; if (obs_addr !== word_addr(1, 2)) begin
            n_fail++; $display("FAIL rst_after_addr got=%h exp=%h", obs_addr, word_addr(1, 2));
        end
    endtask

    task automatic test_random_traffic();
        logic [NUM_REQ-1:0] req_seen;
        int v;
        pulse_reset();
        clear_words();
        v = 760;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (words_left[i] == 0 && $urandom_range(0, 3) == 0) words_left[i] = $urandom_range(1, 12);
            end
            if (t % 4 == 0) v = (v >= 805) ? 760 : v + 1;
            vcount = 11'(v);
            tick();
            req_seen = req;
            n_tests++;
            if (obs_ack != 0) begin
                if (!$onehot(obs_ack) || (obs_ack & ~req_seen) != 0 || !tb_win ||
                    obs_we !== 1'b1 || obs_addr !== exp_addr || obs_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL random_t%0d got ack=%b req=%b v=%0d we=%b %h/%h exp %h/%h",
                             t, obs_ack, req_seen, v, obs_we, obs_addr, obs_data, exp_addr, exp_data);
                end
            end else if (obs_we !== 1'b0) begin
                n_fail++;
                $display("FAIL random_t%0d_we got=%b exp=0", t, obs_we);
            end
        end
        $display("[TB] random traffic: 400 cycles done");
    endtask

    initial begin
        rst_n    = 1'b0;
        vcount   = '0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        clear_words();
        @(posedge clk);
        #1;
        test_reset();
        test_single_burst();
        test_contention();
        test_window_close();
        test_reset_mid_burst();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
